// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin writeback arbiter for the register file write port (optional WB_BYPASS_EN bypass)
module rf_wb_arbiter #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = $clog2(NREGS),
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             alu_valid,
   output logic             alu_ready,
   input  logic [AW-1:0]    alu_rd,
   input  logic [XLEN-1:0]  alu_data,
   input  logic             mem_valid,
   output logic             mem_ready,
   input  logic [AW-1:0]    mem_rd,
   input  logic [XLEN-1:0]  mem_data,
   output logic             rf_write,
   output logic [AW-1:0]    rf_waddr,
   output logic [XLEN-1:0]  rf_wdata,
   input  logic [AW-1:0]    rd_addr1,
   input  logic [AW-1:0]    rd_addr2,
   output logic             byp_hit1,
   output logic             byp_hit2,
   output logic [XLEN-1:0]  byp_data1,
   output logic [XLEN-1:0]  byp_data2,
   output logic [CNT_W-1:0] conflict_cnt
);

   localparam logic GRANT_ALU = 1'b0;
   localparam logic GRANT_MEM = 1'b1;

   logic last_grant;
   logic last_grant_nxt;
   logic grant_alu;
   logic grant_mem;
   logic both_valid;

   assign both_valid = alu_valid && mem_valid;

   // Round-robin state: remembers which source won the most recent transfer
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant <= GRANT_ALU;
      end else begin
         last_grant <= last_grant_nxt;
      end
   end

   // Next state follows the granted source, holds when nothing transfers
   always_comb begin
      last_grant_nxt = last_grant;
      if (grant_alu) begin
         last_grant_nxt = GRANT_ALU;
      end else if (grant_mem) begin
         last_grant_nxt = GRANT_MEM;
      end
   end

   // Grant decode: a lone requester wins, a tie goes to whoever did not win last
   always_comb begin
      grant_alu = 1'b0;
      grant_mem = 1'b0;
      if (reset_n) begin
         if (both_valid) begin
            if (last_grant == GRANT_ALU) begin
               grant_mem = 1'b1;
            end else begin
               grant_alu = 1'b1;
            end
         end else begin
            grant_alu = alu_valid;
            grant_mem = mem_valid;
         end
      end
   end

   assign alu_ready = grant_alu;
   assign mem_ready = grant_mem;

   // Registered write stage; x0 destinations are accepted but never written
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rf_write <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else if (grant_alu) begin
         rf_write <= (alu_rd != '0);
         rf_waddr <= alu_rd;
         rf_wdata <= alu_data;
      end else if (grant_mem) begin
         rf_write <= (mem_rd != '0);
         rf_waddr <= mem_rd;
         rf_wdata <= mem_data;
      end else begin
         rf_write <= 1'b0;
      end
   end

   // Saturating count of cycles in which one requester had to wait
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         conflict_cnt <= '0;
      end else if (both_valid && (conflict_cnt != {CNT_W{1'b1}})) begin
         conflict_cnt <= conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

`ifdef WB_BYPASS_EN
   assign byp_hit1  = rf_write && (rf_waddr == rd_addr1) && (rd_addr1 != '0);
   assign byp_hit2  = rf_write && (rf_waddr == rd_addr2) && (rd_addr2 != '0);
   assign byp_data1 = byp_hit1 ? rf_wdata : '0;
   assign byp_data2 = byp_hit2 ? rf_wdata : '0;
`else
   logic unused_rd_addr;
   assign unused_rd_addr = ^{rd_addr1, rd_addr2};
   assign byp_hit1  = 1'b0;
   assign byp_hit2  = 1'b0;
   assign byp_data1 = '0;
   assign byp_data2 = '0;
`endif

endmodule
